tl_line_master: RTL and testbench
=================================

TL_LINE_MASTER -- requirements
Module: tl_line_master

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: byte address width; SHALL be at least 7.
REQ-002 Parameter SOURCE_WIDTH, default 2: TL source width; NSRC = 2^SOURCE_WIDTH outstanding transactions.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  line-command handshake.
REQ-006 cmd_write  in  1  1=PutFull 64 B, 0=Get 64 B.
REQ-007 cmd_address  in  ADDRESS_WIDTH  line address; bits [5:0] ignored, driven as 0 on A.
REQ-008 cmd_tag  out  SOURCE_WIDTH  source allocated to the command accepted this cycle.
REQ-009 wr_valid/wr_ready/wr_data  in/out/in  1/1/64  write beat stream, 8 beats per write command.
REQ-010 rd_valid/rd_ready/rd_data/rd_tag/rd_last  out/in/out/out/out  1/1/64/SOURCE_WIDTH/1  read beat stream.
REQ-011 wack_valid/wack_tag  out/out  1/SOURCE_WIDTH  one-cycle write-acknowledge pulse.
REQ-012 error  out  1  sticky; denied or corrupt response seen.
REQ-013 busy  out  1  any source in use or A burst in progress.
REQ-014 tl_a_valid/ready/opcode/param/source/address/size/mask/data/corrupt  out/in/out 3/out 3/out SOURCE_WIDTH/out ADDRESS_WIDTH/out 3/out 8/out 64/out 1  TL-UL A channel.
REQ-015 tl_d_valid/ready/opcode/param/source/size/denied/data/corrupt  in/out/in 3/in 3/in SOURCE_WIDTH/in 3/in 1/in 64/in 1  TL-UL D channel.

Function
REQ-016 A-side FSM states IDLE, GET, PUT; held in IDLE while reset.
REQ-017 cmd_ready SHALL be 1 only in IDLE with at least one free source; free-source bitmap of NSRC bits.
REQ-018 On cmd fire: allocate lowest-numbered free source, drive it on cmd_tag, latch address/source, go GET (cmd_write=0) or PUT (cmd_write=1).
REQ-019 Constant A fields: param 0, size 6, mask 8'hFF, corrupt 0; opcode 4 in GET, 0 in PUT.
REQ-020 GET: tl_a_valid=1, data don't-care; on tl_a_ready -> IDLE; one beat per Get.
REQ-021 PUT: tl_a_valid=wr_valid, wr_ready=tl_a_ready, tl_a_data=wr_data; address/source constant across all 8 beats.
REQ-022 PUT beat counter 3 bits, increments on A fire; fire with counter 7 -> IDLE, counter wraps to 0.
REQ-023 wr_ready SHALL be 0 outside PUT; tl_a_valid SHALL be 0 in IDLE.
REQ-024 No combinational path from tl_a_ready to tl_a_valid.
REQ-025 D opcode 1 (ReadData): rd_valid=tl_d_valid, tl_d_ready=rd_ready, rd_data/rd_tag from D; responses are beat-contiguous per source.
REQ-026 D read beat counter 3 bits; rd_last=1 on beat 7; fire of beat 7 frees tl_d_source.
REQ-027 D opcode 0 (AccessAck): tl_d_ready=1, on fire wack_valid=1 next cycle with wack_tag=source, source freed.
REQ-028 rd_valid SHALL be 0 when D opcode is not 1.
REQ-029 Any D fire with tl_d_denied or tl_d_corrupt sets error; cleared only by reset; transaction still completes normally.
REQ-030 Free and allocate in same cycle: both applied; a source freed this cycle is not allocatable until next cycle.
REQ-031 D opcodes other than 0/1: tl_d_ready=1, beat discarded, error set.
REQ-032 busy = any source allocated OR state != IDLE.

Reset
REQ-033 Reset asserted: state IDLE, bitmap all free, beat counters 0, error 0, wack_valid 0, tl_a_valid 0, cmd_ready 0 while reset high.
REQ-034 Reset mid-burst aborts in-flight A burst and discards pending responses; no pulse or output beat afterwards from pre-reset transactions.
REQ-035 First cycle after reset release: cmd_ready=1.

Verification
REQ-036 Get 0x1000_0040, zero-latency responder -> one A beat opcode 4 addr 0x1000_0040 size 6 source 0; 8 rd beats, rd_last on 8th; source 0 freed.
REQ-037 Put 0x2000_0000, data 0..7, wr_valid gaps and a_ready stalls -> 8 A beats opcode 0, data 0..7 in order, constant address; AccessAck source 0 -> wack_valid one cycle, tag 0.
REQ-038 SOURCE_WIDTH=2, 4 Gets without responses -> tags 0,1,2,3; cmd_ready=0 after 4th; respond source 2 -> next command tag 2.
REQ-039 rd_ready toggled 50% during read burst -> tl_d_ready mirrors rd_ready, no beat lost or duplicated.
REQ-040 AccessAck with denied=1 -> error=1, stays 1 through further traffic, 0 after reset.
REQ-041 Reset at PUT beat 4 -> tl_a_valid 0 immediately, busy 0, cmd_ready 1 after release.

Source files
------------

// File: rtl/tl_line_master.sv
// tl_line_master: turns 64-byte line commands (Get / PutFull) into TL-UL
// bursts on the A channel and returns read beats or write acks from D.
// Up to 2^SOURCE_WIDTH transactions may be outstanding, one per source id.
module tl_line_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int SOURCE_WIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  // line command
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_address,
  output logic [SOURCE_WIDTH-1:0]  cmd_tag,
  // write beat stream
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [63:0]              wr_data,
  // read beat stream
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [63:0]              rd_data,
  output logic [SOURCE_WIDTH-1:0]  rd_tag,
  output logic                     rd_last,
  // write acknowledge
  output logic                     wack_valid,
  output logic [SOURCE_WIDTH-1:0]  wack_tag,
  // status
  output logic                     error,
  output logic                     busy,
  // TL-UL A channel
  output logic                     tl_a_valid,
  input  logic                     tl_a_ready,
  output logic [2:0]               tl_a_opcode,
  output logic [2:0]               tl_a_param,
  output logic [SOURCE_WIDTH-1:0]  tl_a_source,
  output logic [ADDRESS_WIDTH-1:0] tl_a_address,
  output logic [2:0]               tl_a_size,
  output logic [7:0]               tl_a_mask,
  output logic [63:0]              tl_a_data,
  output logic                     tl_a_corrupt,
  // TL-UL D channel
  input  logic                     tl_d_valid,
  output logic                     tl_d_ready,
  input  logic [2:0]               tl_d_opcode,
  input  logic [2:0]               tl_d_param,
  input  logic [SOURCE_WIDTH-1:0]  tl_d_source,
  input  logic [2:0]               tl_d_size,
  input  logic                     tl_d_denied,
  input  logic [63:0]              tl_d_data,
  input  logic                     tl_d_corrupt
);

  localparam int NSRC = 1 << SOURCE_WIDTH;

  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_PUTFULL  = 3'd0;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACKDATA  = 3'd1;

  typedef enum logic [1:0] {IDLE, GET, PUT} state_t;

  state_t                     state;
  logic [NSRC-1:0]            alloc;      // 1 = source in flight
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [SOURCE_WIDTH-1:0]    src_q;
  logic [2:0]                 opcode_q;
  logic [2:0]                 put_cnt;
  logic [2:0]                 rd_cnt;

  logic                       any_free;
  logic [SOURCE_WIDTH-1:0]    free_idx;
  logic                       cmd_fire;
  logic                       a_fire;
  logic [NSRC-1:0]            alloc_mask;
  logic [NSRC-1:0]            free_mask;

  logic                       d_owned;
  logic                       d_is_rd;
  logic                       d_is_ack;
  logic                       d_fire;
  logic                       rd_fire;
  logic                       ack_fire;
  logic                       d_err;

  // Fields we never look at; low address bits are forced to zero on A.
  logic unused_ok;
  assign unused_ok = ^{tl_d_param, tl_d_size, cmd_address[5:0]};

  // Lowest-numbered free source; the registered bitmap is used so a source
  // released this cycle only becomes allocatable on the next one.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (!alloc[i]) begin
        any_free = 1'b1;
        free_idx = SOURCE_WIDTH'(i);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Command side / A channel
  // ---------------------------------------------------------------------
  assign cmd_ready  = !reset && (state == IDLE) && any_free;
  assign cmd_tag    = free_idx;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign alloc_mask = cmd_fire ? (NSRC'(1) << free_idx) : '0;

  // tl_a_valid depends only on state and wr_valid, never on tl_a_ready.
  assign tl_a_valid   = (state == GET) || ((state == PUT) && wr_valid);
  assign wr_ready     = (state == PUT) && tl_a_ready;
  assign a_fire       = tl_a_valid && tl_a_ready;

  assign tl_a_opcode  = opcode_q;
  assign tl_a_param   = 3'd0;
  assign tl_a_source  = src_q;
  assign tl_a_address = addr_q;
  assign tl_a_size    = 3'd6;
  assign tl_a_mask    = 8'hFF;
  assign tl_a_data    = (state == PUT) ? wr_data : 64'd0;
  assign tl_a_corrupt = 1'b0;

  // A-side FSM: latch the command, then issue one Get beat or eight Put beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      src_q    <= '0;
      opcode_q <= OP_PUTFULL;
      put_cnt  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            addr_q   <= {cmd_address[ADDRESS_WIDTH-1:6], 6'b0};
            src_q    <= free_idx;
            opcode_q <= cmd_write ? OP_PUTFULL : OP_GET;
            state    <= cmd_write ? PUT : GET;
          end
        end
        GET: begin
          if (a_fire) state <= IDLE;
        end
        PUT: begin
          if (a_fire) begin
            put_cnt <= put_cnt + 3'd1;
            if (put_cnt == 3'd7) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // D channel
  // ---------------------------------------------------------------------
  // Beats for a source that is not in flight (e.g. left over from before a
  // reset) are drained silently so they never reach the user side.
  assign d_owned  = alloc[tl_d_source];
  assign d_is_rd  = (tl_d_opcode == OP_ACKDATA);
  assign d_is_ack = (tl_d_opcode == OP_ACK);

  assign rd_valid   = tl_d_valid && d_is_rd && d_owned;
  assign tl_d_ready = (d_is_rd && d_owned) ? rd_ready : 1'b1;
  assign rd_data    = tl_d_data;
  assign rd_tag     = tl_d_source;
  assign rd_last    = (rd_cnt == 3'd7);

  assign d_fire   = tl_d_valid && tl_d_ready;
  assign rd_fire  = d_fire && d_is_rd && d_owned;
  assign ack_fire = d_fire && d_is_ack && d_owned;
  assign d_err    = d_fire && d_owned &&
                    (tl_d_denied || tl_d_corrupt || !(d_is_rd || d_is_ack));

  assign free_mask = ((rd_fire && rd_last) || ack_fire)
                     ? (NSRC'(1) << tl_d_source) : '0;

  // Source bitmap: release on completion, claim on command, both in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) alloc <= '0;
    else       alloc <= (alloc & ~free_mask) | alloc_mask;
  end

  // Read beat counter, ack pulse and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt     <= 3'd0;
      wack_valid <= 1'b0;
      wack_tag   <= '0;
      error      <= 1'b0;
    end else begin
      if (rd_fire) rd_cnt <= rd_cnt + 3'd1;
      wack_valid <= ack_fire;
      if (ack_fire) wack_tag <= tl_d_source;
      if (d_err) error <= 1'b1;
    end
  end

  assign busy = (|alloc) || (state != IDLE);

endmodule

// File: tb/tb_tl_line_master.sv
// Directed bench for tl_line_master: Get/Put bursts, source allocation,
// read backpressure, error stickiness and reset mid-burst.
module tb_tl_line_master;

  localparam int AW = 32;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_address;
  logic [SW-1:0] cmd_tag;
  logic          wr_valid, wr_ready;
  logic [63:0]   wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [63:0]   rd_data;
  logic [SW-1:0] rd_tag;
  logic          wack_valid;
  logic [SW-1:0] wack_tag;
  logic          error, busy;
  logic          tl_a_valid, tl_a_ready, tl_a_corrupt;
  logic [2:0]    tl_a_opcode, tl_a_param, tl_a_size;
  logic [SW-1:0] tl_a_source;
  logic [AW-1:0] tl_a_address;
  logic [7:0]    tl_a_mask;
  logic [63:0]   tl_a_data;
  logic          tl_d_valid, tl_d_ready, tl_d_denied, tl_d_corrupt;
  logic [2:0]    tl_d_opcode, tl_d_param, tl_d_size;
  logic [SW-1:0] tl_d_source;
  logic [63:0]   tl_d_data;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  tl_line_master #(.ADDRESS_WIDTH(AW), .SOURCE_WIDTH(SW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_tag(cmd_tag),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_tag(rd_tag), .rd_last(rd_last),
    .wack_valid(wack_valid), .wack_tag(wack_tag),
    .error(error), .busy(busy),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
    .tl_a_param(tl_a_param), .tl_a_source(tl_a_source), .tl_a_address(tl_a_address),
    .tl_a_size(tl_a_size), .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
    .tl_a_corrupt(tl_a_corrupt),
    .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
    .tl_d_param(tl_d_param), .tl_d_source(tl_d_source), .tl_d_size(tl_d_size),
    .tl_d_denied(tl_d_denied), .tl_d_data(tl_d_data), .tl_d_corrupt(tl_d_corrupt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_address = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;
    tl_a_ready = 0;
    tl_d_valid = 0; tl_d_opcode = 3'd0; tl_d_param = 3'd0; tl_d_source = '0;
    tl_d_size = 3'd6; tl_d_denied = 0; tl_d_data = '0; tl_d_corrupt = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
  endtask

  // Present a command, check the handshake and tag, and let it fire.
  task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr, input int exp_tag);
    cmd_valid = 1; cmd_write = wr; cmd_address = addr;
    #1;
    chk("cmd_ready", cmd_ready, 1);
    chk("cmd_tag", cmd_tag, exp_tag);
    step();
    cmd_valid = 0;
    #1;
  endtask

  // Eight ReadData beats with rd_ready held high.
  task automatic read_burst(input int src, input logic [63:0] base);
    for (int i = 0; i < 8; i++) begin
      tl_d_valid = 1; tl_d_opcode = 3'd1; tl_d_source = SW'(src);
      tl_d_data = base + 64'(i); rd_ready = 1;
      #1;
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, base + 64'(i));
      chk("rd_tag", rd_tag, src);
      chk("rd_last", rd_last, (i == 7));
      step();
    end
    tl_d_valid = 0; rd_ready = 0;
    #1;
  endtask

  task automatic put_burst_fast();
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1; tl_a_ready = 1; wr_data = 64'(i);
      step();
    end
    wr_valid = 0; tl_a_ready = 0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int b, cyc;
    reset = 1;
    idle_inputs();
    #1;
    // ---- reset state
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_a_valid", tl_a_valid, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_error", error, 0);
    chk("rst_wack", wack_valid, 0);
    reset = 0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // ---- Get 0x1000_0040 (low bits ignored)
    issue_cmd(0, 32'h1000_0047, 0);
    chk("get_a_valid", tl_a_valid, 1);
    chk("get_opcode", tl_a_opcode, 4);
    chk("get_addr", tl_a_address, 32'h1000_0040);
    chk("get_size", tl_a_size, 6);
    chk("get_source", tl_a_source, 0);
    chk("get_mask", tl_a_mask, 8'hFF);
    chk("get_param", tl_a_param, 0);
    chk("get_corrupt", tl_a_corrupt, 0);
    chk("get_wr_ready", wr_ready, 0);
    chk("get_cmd_ready", cmd_ready, 0);
    tl_a_ready = 1;
    step();
    tl_a_ready = 0;
    #1;
    chk("get_done_a_valid", tl_a_valid, 0);
    chk("get_busy", busy, 1);
    read_burst(0, 64'h100);
    chk("get_freed_busy", busy, 0);

    // ---- Put 0x2000_0000 with wr_valid gaps and a_ready stalls
    issue_cmd(1, 32'h2000_0000, 0);
    b = 0; cyc = 0;
    while (b < 8 && cyc < 100) begin
      wr_valid = ((cyc % 3) != 1); tl_a_ready = ((cyc % 4) != 2); wr_data = 64'(b);
      #1;
      chk("put_a_valid", tl_a_valid, wr_valid);
      chk("put_wr_ready", wr_ready, tl_a_ready);
      if (wr_valid && tl_a_ready) begin
        chk("put_data", tl_a_data, 64'(b));
        chk("put_addr", tl_a_address, 32'h2000_0000);
        chk("put_opcode", tl_a_opcode, 0);
        chk("put_source", tl_a_source, 0);
        b++;
      end
      step();
      cyc++;
    end
    chk("put_beats", b, 8);
    wr_valid = 1; tl_a_ready = 1;
    #1;
    chk("put_end_wr_ready", wr_ready, 0);
    chk("put_end_a_valid", tl_a_valid, 0);
    wr_valid = 0; tl_a_ready = 0;
    tl_d_valid = 1; tl_d_opcode = 3'd0; tl_d_source = 2'd0;
    #1;
    chk("ack_d_ready", tl_d_ready, 1);
    chk("ack_rd_valid", rd_valid, 0);
    step();
    tl_d_valid = 0;
    #1;
    chk("wack_valid", wack_valid, 1);
    chk("wack_tag", wack_tag, 0);
    step();
    chk("wack_one_cycle", wack_valid, 0);
    chk("put_freed_busy", busy, 0);

    // ---- four outstanding Gets, then free source 2
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue_cmd(0, 32'h3000_0000 + 32'(k * 64), k);
      tl_a_ready = 1;
      step();
      tl_a_ready = 0;
      #1;
    end
    cmd_valid = 1;
    #1;
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    cmd_valid = 0;
    read_burst(2, 64'h200);
    issue_cmd(0, 32'h3000_0400, 2);

    // ---- rd_ready toggling
    do_reset();
    issue_cmd(0, 32'h4000_0000, 0);
    tl_a_ready = 1;
    step();
    tl_a_ready = 0;
    b = 0; cyc = 0;
    while (b < 8 && cyc < 40) begin
      tl_d_valid = 1; tl_d_opcode = 3'd1; tl_d_source = 2'd0;
      tl_d_data = 64'hA0 + 64'(b); rd_ready = (cyc % 2) == 0;
      #1;
      chk("bp_d_ready", tl_d_ready, rd_ready);
      chk("bp_rd_data", rd_data, 64'hA0 + 64'(b));
      chk("bp_rd_last", rd_last, (b == 7));
      if (rd_ready) b++;
      step();
      cyc++;
    end
    tl_d_valid = 0; rd_ready = 0;
    #1;
    chk("bp_beats", b, 8);
    chk("bp_cycles", cyc, 15);
    chk("bp_busy", busy, 0);

    // ---- denied AccessAck sets sticky error
    do_reset();
    issue_cmd(1, 32'h5000_0000, 0);
    put_burst_fast();
    tl_d_valid = 1; tl_d_opcode = 3'd0; tl_d_source = 2'd0; tl_d_denied = 1;
    step();
    tl_d_valid = 0; tl_d_denied = 0;
    #1;
    chk("den_wack", wack_valid, 1);
    chk("den_error", error, 1);
    issue_cmd(0, 32'h5000_0040, 0);
    tl_a_ready = 1;
    step();
    tl_a_ready = 0;
    read_burst(0, 64'h300);
    chk("den_error_sticky", error, 1);
    do_reset();
    chk("den_error_cleared", error, 0);

    // ---- unknown D opcode is drained and flagged
    issue_cmd(0, 32'h6000_0000, 0);
    tl_a_ready = 1;
    step();
    tl_a_ready = 0;
    tl_d_valid = 1; tl_d_opcode = 3'd2; tl_d_source = 2'd0; rd_ready = 0;
    #1;
    chk("badop_rd_valid", rd_valid, 0);
    chk("badop_d_ready", tl_d_ready, 1);
    step();
    tl_d_valid = 0;
    #1;
    chk("badop_error", error, 1);
    chk("badop_busy", busy, 1);

    // ---- reset at Put beat 4
    do_reset();
    issue_cmd(1, 32'h7000_0000, 0);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; tl_a_ready = 1; wr_data = 64'(i);
      step();
    end
    reset = 1;
    #1;
    chk("mid_rst_a_valid", tl_a_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    wr_valid = 0; tl_a_ready = 0;
    step();
    step();
    reset = 0;
    #1;
    chk("after_rst_cmd_ready", cmd_ready, 1);
    tl_d_valid = 1; tl_d_opcode = 3'd0; tl_d_source = 2'd0;
    #1;
    chk("stale_d_ready", tl_d_ready, 1);
    step();
    tl_d_opcode = 3'd1; rd_ready = 1;
    #1;
    chk("stale_wack", wack_valid, 0);
    chk("stale_rd_valid", rd_valid, 0);
    tl_d_valid = 0; rd_ready = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
